// File: rtl/rr_grant_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
// State encoding, sizing constants and the rotating priority search.
package rr_grant_arbiter_pkg;

    localparam int NREQ         = 4;
    localparam int IDX_W        = 2;
    localparam int MAX_HOLD_DEF = 15;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // First requester found scanning ptr, ptr+1, ... modulo NREQ.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NREQ-1:0]  req,
        input logic [IDX_W-1:0] ptr
    );
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// The arbiter takes the slave side; the requester side is master.
interface rr_grant_arbiter_if
    import rr_grant_arbiter_pkg::*;
();

    logic             en;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_vld;
    logic             timeout;

    modport master (
        output en,
        output req,
        input  grant,
        input  grant_idx,
        input  grant_vld,
        input  timeout
    );

    modport slave (
        input  en,
        input  req,
        output grant,
        output grant_idx,
        output grant_vld,
        output timeout
    );

endinterface

// File: rtl/rr_grant_arbiter_dec2to4.sv
// 2-to-4 one-hot grant decoder with enable.
// Output is all-zero whenever the enable is low.
module rr_grant_arbiter_dec2to4
    import rr_grant_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [NREQ-1:0]  dout
);

    always_comb begin
        dout = '0;
        if (en) begin
            unique case (1'b1)
                (idx == 2'd0): dout = 4'b0001;
                (idx == 2'd1): dout = 4'b0010;
                (idx == 2'd2): dout = 4'b0100;
                (idx == 2'd3): dout = 4'b1000;
            endcase
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: one owner at a time, bounded hold, rotating priority.
// All outputs are registers or a decode of registers.
module rr_grant_arbiter
    import rr_grant_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_grant_arbiter_if.slave  bus
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  gidx;
    logic [HOLD_W-1:0] hold_cnt;
    logic              vld;
    logic              tmo;
    logic              owner_req;

    assign owner_req = bus.req[gidx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            gidx     <= '0;
            hold_cnt <= '0;
            vld      <= 1'b0;
            tmo      <= 1'b0;
        end else begin
            tmo <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.en && (|bus.req)) begin
                        gidx     <= rr_pick(bus.req, ptr);
                        hold_cnt <= '0;
                        vld      <= 1'b1;
                        state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                    // Release always passes through IDLE for a turnaround cycle.
                    if (!bus.en || !owner_req) begin
                        ptr   <= gidx + IDX_W'(1);
                        vld   <= 1'b0;
                        state <= ST_IDLE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        ptr   <= gidx + IDX_W'(1);
                        vld   <= 1'b0;
                        tmo   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    rr_grant_arbiter_dec2to4 u_dec (
        .idx  (gidx),
        .en   (state == ST_GRANT),
        .dout (bus.grant)
    );

    assign bus.grant_idx = gidx;
    assign bus.grant_vld = vld;
    assign bus.timeout   = tmo;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed ownership vectors
// are queued as expected; a negedge monitor pops and checks them.
module tb_rr_grant_arbiter;
    import rr_grant_arbiter_pkg::*;

    typedef struct {
        int idx;
        int len;
        int to;
        int gap;
    } own_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    rr_grant_arbiter_if bus ();

    rr_grant_arbiter #(
        .MAX_HOLD (15),
        .HOLD_W   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    own_t q[$];
    int   checks = 0;
    int   passed = 0;

    bit   in_own   = 1'b0;
    bit   have_prev = 1'b0;
    int   cur_idx  = 0;
    int   cur_len  = 0;
    int   gap      = 0;
    own_t e;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int idx, input int len,
                        input int to, input int g);
        own_t x;
        x.idx = idx;
        x.len = len;
        x.to  = to;
        x.gap = g;
        q.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
    endtask

    // Monitor: tracks each ownership from first to last grant cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (in_own) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("abort_idx", cur_idx, e.idx);
                end
            end
            in_own    = 1'b0;
            have_prev = 1'b0;
            gap       = 0;
        end else begin
            chk("decode", int'(bus.grant),
                bus.grant_vld ? (1 << bus.grant_idx) : 0);
            if (bus.grant_vld) begin
                if (!in_own) begin
                    if (q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_grant: idx %0d, none expected",
                                 bus.grant_idx);
                    end else if (have_prev && q[0].gap >= 0) begin
                        chk("gap", gap, q[0].gap);
                    end
                    in_own  = 1'b1;
                    cur_idx = int'(bus.grant_idx);
                    cur_len = 1;
                end else begin
                    chk("owner_stable", int'(bus.grant_idx), cur_idx);
                    cur_len++;
                end
                chk("timeout_quiet", int'(bus.timeout), 0);
            end else if (in_own) begin
                in_own    = 1'b0;
                have_prev = 1'b1;
                gap       = 1;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("own_idx", cur_idx, e.idx);
                    chk("own_len", cur_len, e.len);
                    chk("own_timeout", int'(bus.timeout), e.to);
                end
            end else begin
                gap++;
                chk("timeout_quiet", int'(bus.timeout), 0);
            end
        end
    end

    initial begin
        bus.en  = 1'b0;
        bus.req = '0;

        #12;
        chk("rst_grant", int'(bus.grant), 0);
        chk("rst_idx", int'(bus.grant_idx), 0);
        chk("rst_vld", int'(bus.grant_vld), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester, released by dropping its request.
        push(2, 5, 0, -1);
        bus.en  = 1'b1;
        bus.req = 4'b0100;
        cyc(5);
        bus.req = 4'b0000;
        cyc(1);
        chk("t1_drop", int'(bus.grant), 0);
        cyc(1);

        // All requesting: strict rotation 0,1,2,3,0.
        do_reset();
        push(0, 2, 0, -1);
        push(1, 2, 0, 1);
        push(2, 2, 0, 1);
        push(3, 2, 0, 1);
        push(0, 2, 0, 1);
        bus.req = 4'b1111;
        for (int o = 0; o < 5; o++) begin
            cyc(2);
            bus.req[o % 4] = 1'b0;
            if (o == 1) bus.req[0] = 1'b1;
            cyc(1);
        end
        cyc(1);

        // Hold timeout then immediate regrant.
        push(0, 15, 1, -1);
        push(0, 3, 0, 1);
        bus.req = 4'b0001;
        cyc(19);
        bus.req = 4'b0000;
        cyc(2);

        // Ptr=1: index 3 wins before 0 (wrap).
        push(3, 2, 0, -1);
        push(0, 2, 0, 1);
        bus.req = 4'b1001;
        cyc(2);
        bus.req = 4'b0001;
        cyc(3);
        bus.req = 4'b0000;
        cyc(2);

        // Enable drop revokes and blocks.
        push(1, 3, 0, -1);
        bus.req = 4'b0010;
        cyc(3);
        bus.en = 1'b0;
        cyc(1);
        chk("t5_drop", int'(bus.grant), 0);
        chk("t5_timeout", int'(bus.timeout), 0);
        cyc(5);
        chk("t5_blocked", int'(bus.grant_vld), 0);
        push(1, 2, 0, -1);
        bus.en = 1'b1;
        cyc(2);
        bus.req = 4'b0000;
        cyc(2);

        // Async reset mid-grant; ptr=2 so index 2 owns first.
        push(2, -1, 0, -1);
        bus.req = 4'b1111;
        cyc(3);
        chk("t6_pre_vld", int'(bus.grant_vld), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_grant", int'(bus.grant), 0);
        chk("t6_async_vld", int'(bus.grant_vld), 0);
        chk("t6_async_to", int'(bus.timeout), 0);
        @(posedge clk);
        #2;
        push(0, 2, 0, -1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_first", int'(bus.grant), 1);
        cyc(1);
        bus.req = 4'b0000;
        cyc(2);

        for (int i = 0; i < 50 && q.size() > 0; i++) cyc(1);
        chk("queue_drained", q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
